// File: rtl/axi_write_channel_ctrl.sv
// AXI write-channel controller: gives one of two masters the single slave
// write channel for one AW/W/B transaction. The arbiter raises
// Channel_Request and presents a registered Selected_Slave choice.
// All AXI outputs are combinational muxes of the owner register and the FSM
// state, so the controller adds no data latency. The slave-side wlast is
// generated from the beat count. The master wlast is only checked, and a
// mismatch is reported on Wlast_Error.
module axi_write_channel_ctrl #(
  parameter int Addr_Width = 32,
  parameter int Data_Width = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      Channel_Request,
  input  logic                      Selected_Slave,
  output logic                      Channel_Granted,
  // master 0
  input  logic [Addr_Width-1:0]     S00_AXI_awaddr,
  input  logic [7:0]                S00_AXI_awlen,
  input  logic                      S00_AXI_awvalid,
  output logic                      S00_AXI_awready,
  input  logic [Data_Width-1:0]     S00_AXI_wdata,
  input  logic [Data_Width/8-1:0]   S00_AXI_wstrb,
  input  logic                      S00_AXI_wlast,
  input  logic                      S00_AXI_wvalid,
  output logic                      S00_AXI_wready,
  output logic [1:0]                S00_AXI_bresp,
  output logic                      S00_AXI_bvalid,
  input  logic                      S00_AXI_bready,
  // master 1
  input  logic [Addr_Width-1:0]     S01_AXI_awaddr,
  input  logic [7:0]                S01_AXI_awlen,
  input  logic                      S01_AXI_awvalid,
  output logic                      S01_AXI_awready,
  input  logic [Data_Width-1:0]     S01_AXI_wdata,
  input  logic [Data_Width/8-1:0]   S01_AXI_wstrb,
  input  logic                      S01_AXI_wlast,
  input  logic                      S01_AXI_wvalid,
  output logic                      S01_AXI_wready,
  output logic [1:0]                S01_AXI_bresp,
  output logic                      S01_AXI_bvalid,
  input  logic                      S01_AXI_bready,
  // slave side
  output logic [Addr_Width-1:0]     M00_AXI_awaddr,
  output logic [7:0]                M00_AXI_awlen,
  output logic                      M00_AXI_awvalid,
  input  logic                      M00_AXI_awready,
  output logic [Data_Width-1:0]     M00_AXI_wdata,
  output logic [Data_Width/8-1:0]   M00_AXI_wstrb,
  output logic                      M00_AXI_wlast,
  output logic                      M00_AXI_wvalid,
  input  logic                      M00_AXI_wready,
  input  logic [1:0]                M00_AXI_bresp,
  input  logic                      M00_AXI_bvalid,
  output logic                      M00_AXI_bready,
  output logic                      Wlast_Error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [7:0]  beat_limit_q, beat_limit_d;
  logic        wlast_err_q, wlast_err_d;

  // Owner-side view of the two masters
  logic [Addr_Width-1:0]   own_awaddr;
  logic [7:0]              own_awlen;
  logic                    own_awvalid;
  logic [Data_Width-1:0]   own_wdata;
  logic [Data_Width/8-1:0] own_wstrb;
  logic                    own_wlast;
  logic                    own_wvalid;
  logic                    own_bready;
  logic                    last_beat;
  logic                    active;
  logic                    in_addr, in_data, in_resp;

  // Select the owning master's request signals
  always_comb begin
    if (owner_q) begin
      own_awaddr  = S01_AXI_awaddr;
      own_awlen   = S01_AXI_awlen;
      own_awvalid = S01_AXI_awvalid;
      own_wdata   = S01_AXI_wdata;
      own_wstrb   = S01_AXI_wstrb;
      own_wlast   = S01_AXI_wlast;
      own_wvalid  = S01_AXI_wvalid;
      own_bready  = S01_AXI_bready;
    end else begin
      own_awaddr  = S00_AXI_awaddr;
      own_awlen   = S00_AXI_awlen;
      own_awvalid = S00_AXI_awvalid;
      own_wdata   = S00_AXI_wdata;
      own_wstrb   = S00_AXI_wstrb;
      own_wlast   = S00_AXI_wlast;
      own_wvalid  = S00_AXI_wvalid;
      own_bready  = S00_AXI_bready;
    end
  end

  assign last_beat = (beat_cnt_q == beat_limit_q);

  // Next-state, owner, beat counter and wlast check
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    beat_cnt_d   = beat_cnt_q;
    beat_limit_d = beat_limit_q;
    wlast_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Channel_Request) state_d = SELECT;
      end
      SELECT: begin
        // arbiter choice is registered upstream, so it is stable here
        owner_d      = Selected_Slave;
        beat_limit_d = Selected_Slave ? S01_AXI_awlen : S00_AXI_awlen;
        state_d      = ADDR;
      end
      ADDR: begin
        if (own_awvalid && M00_AXI_awready) begin
          // awlen at the handshake is the authoritative burst length
          beat_limit_d = own_awlen;
          beat_cnt_d   = 8'd0;
          state_d      = DATA;
        end
      end
      DATA: begin
        if (own_wvalid && M00_AXI_wready) begin
          wlast_err_d = (own_wlast != last_beat);
          if (last_beat) state_d = RESP;
          else           beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (M00_AXI_bvalid && own_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      beat_cnt_q   <= 8'd0;
      beat_limit_q <= 8'd0;
      wlast_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      beat_cnt_q   <= beat_cnt_d;
      beat_limit_q <= beat_limit_d;
      wlast_err_q  <= wlast_err_d;
    end
  end

  // Reset forces every handshake output low immediately, even mid-transfer
  assign active  = !ARESET;
  assign in_addr = active && (state_q == ADDR);
  assign in_data = active && (state_q == DATA);
  assign in_resp = active && (state_q == RESP);

  // Channel routing: combinational muxes of owner and state
  always_comb begin
    Channel_Granted = active && (state_q == IDLE);

    M00_AXI_awaddr  = own_awaddr;
    M00_AXI_awlen   = own_awlen;
    M00_AXI_awvalid = in_addr && own_awvalid;
    S00_AXI_awready = in_addr && !owner_q && M00_AXI_awready;
    S01_AXI_awready = in_addr &&  owner_q && M00_AXI_awready;

    M00_AXI_wdata   = own_wdata;
    M00_AXI_wstrb   = own_wstrb;
    M00_AXI_wvalid  = in_data && own_wvalid;
    M00_AXI_wlast   = in_data && last_beat;
    S00_AXI_wready  = in_data && !owner_q && M00_AXI_wready;
    S01_AXI_wready  = in_data &&  owner_q && M00_AXI_wready;

    M00_AXI_bready  = in_resp && own_bready;
    S00_AXI_bvalid  = in_resp && !owner_q && M00_AXI_bvalid;
    S01_AXI_bvalid  = in_resp &&  owner_q && M00_AXI_bvalid;
    S00_AXI_bresp   = (in_resp && !owner_q) ? M00_AXI_bresp : 2'b00;
    S01_AXI_bresp   = (in_resp &&  owner_q) ? M00_AXI_bresp : 2'b00;
  end

  assign Wlast_Error = wlast_err_q;

endmodule

// File: tb/tb_axi_write_channel_ctrl.sv
// Directed bench for axi_write_channel_ctrl with a scoreboard: expected AW and
// W beats are queued as the masters drive them and popped by a monitor when
// the slave side handshakes.
module tb_axi_write_channel_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic Channel_Request = 1'b0;
  logic Selected_Slave = 1'b0;
  wire  Channel_Granted;

  logic [AW-1:0] m_awaddr [2];
  logic [7:0]    m_awlen  [2];
  logic [DW-1:0] m_wdata  [2];
  logic [SW-1:0] m_wstrb  [2];
  logic [1:0]    m_awvalid = '0, m_wlast = '0, m_wvalid = '0, m_bready = '0;
  wire  [1:0]    s_awready, s_wready, s_bvalid;
  wire  [1:0]    s_bresp0, s_bresp1;

  logic          sl_awready = 1'b1, sl_wready = 1'b1, sl_bvalid = 1'b0;
  logic [1:0]    sl_bresp = 2'b00;
  wire  [AW-1:0] M00_AXI_awaddr;
  wire  [7:0]    M00_AXI_awlen;
  wire           M00_AXI_awvalid, M00_AXI_wlast, M00_AXI_wvalid, M00_AXI_bready;
  wire  [DW-1:0] M00_AXI_wdata;
  wire  [SW-1:0] M00_AXI_wstrb;
  wire           Wlast_Error;

  axi_write_channel_ctrl #(.Addr_Width(AW), .Data_Width(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .Channel_Request(Channel_Request), .Selected_Slave(Selected_Slave),
    .Channel_Granted(Channel_Granted),
    .S00_AXI_awaddr(m_awaddr[0]), .S00_AXI_awlen(m_awlen[0]),
    .S00_AXI_awvalid(m_awvalid[0]), .S00_AXI_awready(s_awready[0]),
    .S00_AXI_wdata(m_wdata[0]), .S00_AXI_wstrb(m_wstrb[0]),
    .S00_AXI_wlast(m_wlast[0]), .S00_AXI_wvalid(m_wvalid[0]),
    .S00_AXI_wready(s_wready[0]), .S00_AXI_bresp(s_bresp0),
    .S00_AXI_bvalid(s_bvalid[0]), .S00_AXI_bready(m_bready[0]),
    .S01_AXI_awaddr(m_awaddr[1]), .S01_AXI_awlen(m_awlen[1]),
    .S01_AXI_awvalid(m_awvalid[1]), .S01_AXI_awready(s_awready[1]),
    .S01_AXI_wdata(m_wdata[1]), .S01_AXI_wstrb(m_wstrb[1]),
    .S01_AXI_wlast(m_wlast[1]), .S01_AXI_wvalid(m_wvalid[1]),
    .S01_AXI_wready(s_wready[1]), .S01_AXI_bresp(s_bresp1),
    .S01_AXI_bvalid(s_bvalid[1]), .S01_AXI_bready(m_bready[1]),
    .M00_AXI_awaddr(M00_AXI_awaddr), .M00_AXI_awlen(M00_AXI_awlen),
    .M00_AXI_awvalid(M00_AXI_awvalid), .M00_AXI_awready(sl_awready),
    .M00_AXI_wdata(M00_AXI_wdata), .M00_AXI_wstrb(M00_AXI_wstrb),
    .M00_AXI_wlast(M00_AXI_wlast), .M00_AXI_wvalid(M00_AXI_wvalid),
    .M00_AXI_wready(sl_wready), .M00_AXI_bresp(sl_bresp),
    .M00_AXI_bvalid(sl_bvalid), .M00_AXI_bready(M00_AXI_bready),
    .Wlast_Error(Wlast_Error)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard
  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic          mlast;
  } wexp_t;
  wexp_t         w_q[$];
  logic [39:0]   aw_q[$];
  int            tb_owner = -1;
  bit            mon_en = 1'b0;
  logic          pend_err = 1'b0;
  int            w_beats = 0;
  int            err_pulses = 0;

  // slave-side monitor: pops expectations at each handshake
  always @(negedge ACLK) begin
    if (ARESET) begin
      pend_err = 1'b0;
    end else if (mon_en) begin
      chk("wlast_error", {63'd0, Wlast_Error}, {63'd0, pend_err});
      if (Wlast_Error === 1'b1) err_pulses++;
      pend_err = 1'b0;
      if (M00_AXI_awvalid && sl_awready) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
        else chk("aw_addr_len", {24'd0, M00_AXI_awaddr, M00_AXI_awlen}, {24'd0, aw_q.pop_front()});
      end
      if (M00_AXI_wvalid && sl_wready) begin
        if (w_q.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
        else begin
          wexp_t e;
          e = w_q.pop_front();
          w_beats++;
          chk("w_data_strb", {28'd0, M00_AXI_wdata, M00_AXI_wstrb}, {28'd0, e.data, e.strb});
          chk("w_last", {63'd0, M00_AXI_wlast}, {63'd0, e.last});
          pend_err = (e.mlast != e.last);
        end
      end
      if (tb_owner >= 0)
        chk("nonowner_quiet", {61'd0, s_awready[1-tb_owner], s_wready[1-tb_owner],
                               s_bvalid[1-tb_owner]}, 64'd0);
    end
  end

  // one complete (or aborted) transfer from master m
  task automatic xfer(input int m, input logic [31:0] addr, input int len, input int bad_beat,
                      input bit toggle, input int abort_after, input logic [1:0] resp,
                      output int cycles);
    int n;
    bit hs;
    wexp_t e;
    cycles = 0;
    n = 0;
    while (Channel_Granted !== 1'b1 && n < 20) begin
      @(posedge ACLK); #1; n++;
    end
    chk("grant_before_xfer", {63'd0, Channel_Granted}, 64'd1);
    tb_owner = m;
    sl_awready = 1'b1; sl_wready = 1'b1;
    Channel_Request = 1'b1; Selected_Slave = m[0];
    m_awaddr[m] = addr; m_awlen[m] = 8'(len); m_awvalid[m] = 1'b1;
    aw_q.push_back({addr, 8'(len)});
    hs = 0; n = 0;
    while (!hs && n < 20) begin
      @(negedge ACLK); hs = M00_AXI_awvalid && sl_awready;
      @(posedge ACLK); #1; cycles++; n++;
      Channel_Request = 1'b0;
    end
    m_awvalid[m] = 1'b0;
    if (!hs) begin chk("aw_timeout", 64'd0, 64'd1); tb_owner = -1; return; end
    for (int i = 0; i <= len; i++) begin
      if (abort_after >= 0 && i == abort_after) begin
        ARESET = 1'b1; sl_wready = 1'b1;     // master still shows wvalid
        @(negedge ACLK);
        chk("rst_granted_low", {63'd0, Channel_Granted}, 64'd0);
        chk("rst_m00_wvalid", {63'd0, M00_AXI_wvalid}, 64'd0);
        chk("rst_owner_wready", {63'd0, s_wready[m]}, 64'd0);
        @(posedge ACLK); #1; @(posedge ACLK); #1;
        m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0; sl_bvalid = 1'b1; m_bready[m] = 1'b1;
        ARESET = 1'b0; tb_owner = -1;
        @(negedge ACLK);
        chk("rst_release_grant", {63'd0, Channel_Granted}, 64'd1);
        chk("rst_no_bvalid", {62'd0, s_bvalid}, 64'd0);
        chk("rst_wlast_error", {63'd0, Wlast_Error}, 64'd0);
        @(posedge ACLK); #1;
        sl_bvalid = 1'b0; m_bready[m] = 1'b0;
        return;
      end
      e.data = $urandom; e.strb = SW'($urandom);
      e.last = (i == len);
      e.mlast = (i == len) ^ (i == bad_beat);
      m_wdata[m] = e.data; m_wstrb[m] = e.strb; m_wlast[m] = e.mlast; m_wvalid[m] = 1'b1;
      w_q.push_back(e);
      hs = 0; n = 0;
      while (!hs && n < 20) begin
        sl_wready = toggle ? ~sl_wready : 1'b1;
        @(negedge ACLK); hs = M00_AXI_wvalid && sl_wready;
        @(posedge ACLK); #1; cycles++; n++;
      end
      if (!hs) begin chk("w_timeout", 64'd0, 64'd1); m_wvalid[m] = 1'b0; tb_owner = -1; return; end
    end
    m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0;
    sl_bvalid = 1'b1; sl_bresp = resp; m_bready[m] = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 20) begin
      @(negedge ACLK);
      hs = s_bvalid[m] && m_bready[m];
      if (hs) chk("b_resp", {62'd0, (m == 0) ? s_bresp0 : s_bresp1}, {62'd0, resp});
      @(posedge ACLK); #1; cycles++; n++;
    end
    sl_bvalid = 1'b0; m_bready[m] = 1'b0; tb_owner = -1;
    if (!hs) begin chk("b_timeout", 64'd0, 64'd1); return; end
    @(negedge ACLK);
    chk("grant_after_b", {63'd0, Channel_Granted}, 64'd1);
    @(posedge ACLK); #1;
  endtask

  int cyc, beats0, pulses0;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_awaddr[k] = '0; m_awlen[k] = '0; m_wdata[k] = '0; m_wstrb[k] = '0;
    end
    // reset behaviour
    @(negedge ACLK);
    chk("reset_granted", {63'd0, Channel_Granted}, 64'd0);
    chk("reset_awvalid", {63'd0, M00_AXI_awvalid}, 64'd0);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_wlast_error", {63'd0, Wlast_Error}, 64'd0);
    chk("reset_readies", {58'd0, s_awready, s_wready, s_bvalid}, 64'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("grant_after_reset", {63'd0, Channel_Granted}, 64'd1);
    mon_en = 1'b1;
    @(posedge ACLK); #1;

    // M0 single beat, zero-wait slave: 5 cycles
    xfer(0, 32'h0000_1000, 0, -1, 1'b0, -1, 2'b00, cyc);
    chk("single_beat_cycles", 64'(cyc), 64'd5);

    // M1 burst of 4 with toggling wready
    beats0 = w_beats; pulses0 = err_pulses;
    xfer(1, 32'h0000_2000, 3, -1, 1'b1, -1, 2'b10, cyc);
    chk("burst4_beats", 64'(w_beats - beats0), 64'd4);
    chk("burst4_no_err", 64'(err_pulses - pulses0), 64'd0);

    // M0 awlen=1 with early wlast on beat 1
    beats0 = w_beats; pulses0 = err_pulses;
    xfer(0, 32'h0000_3000, 1, 0, 1'b0, -1, 2'b01, cyc);
    chk("early_wlast_pulses", 64'(err_pulses - pulses0), 64'd1);
    chk("early_wlast_beats", 64'(w_beats - beats0), 64'd2);

    // M1 owns the channel while M0 holds awvalid/wvalid high
    m_awaddr[0] = 32'h0000_BAD0; m_awvalid[0] = 1'b1;
    m_wdata[0] = 32'hDEAD_BEEF; m_wvalid[0] = 1'b1; m_wlast[0] = 1'b1;
    xfer(1, 32'h0000_4000, 2, -1, 1'b1, -1, 2'b11, cyc);
    m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0; m_wlast[0] = 1'b0;
    xfer(0, 32'h0000_5000, 0, -1, 1'b0, -1, 2'b10, cyc);

    // reset in DATA after 2 of 4 beats, then a normal transfer
    beats0 = w_beats;
    xfer(0, 32'h0000_6000, 3, -1, 1'b0, 2, 2'b00, cyc);
    chk("abort_beats", 64'(w_beats - beats0), 64'd2);
    xfer(1, 32'h0000_7000, 0, -1, 1'b0, -1, 2'b01, cyc);

    // longest burst: 256 beats
    beats0 = w_beats; pulses0 = err_pulses;
    xfer(1, 32'h0000_8000, 255, -1, 1'b0, -1, 2'b00, cyc);
    chk("burst256_beats", 64'(w_beats - beats0), 64'd256);
    chk("burst256_no_err", 64'(err_pulses - pulses0), 64'd0);

    chk("aw_queue_empty", 64'(aw_q.size()), 64'd0);
    chk("w_queue_empty", 64'(w_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
